// File: rtl/stream_delta_decoder.sv
// ============================================================================
// Module   : stream_delta_decoder
// Purpose  : Inverse of the running-sum stream kernel. Each accepted 32-bit
//            cumulative-sum word x is turned into x - prev (modulo 2^W) and
//            pushed into a 2-entry output buffer that decouples the input and
//            output handshakes (no combinational path s1o_rdy -> s1i_rdy).
// Options  : define STREAM_DELTA_WORDCOUNT_EN to add the 32-bit word_count
//            output counting output transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_delta_decoder #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s1i_valid,
  output logic         s1i_rdy,
  input  logic [W-1:0] s1i_data,
  output logic         s1o_valid,
  input  logic         s1o_rdy,
  output logic [W-1:0] s1o_data
`ifdef STREAM_DELTA_WORDCOUNT_EN
  ,
  output logic [31:0]  word_count
`endif
);

  // Predecessor word, buffer entries (head is the one presented downstream)
  // and buffer occupancy in {0,1,2}.
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q,  cnt_d;

  logic         push;
  logic         pop;
  logic [W-1:0] delta;

  // Handshake outputs come from registered occupancy only; rst gates the
  // input ready so nothing is accepted while the block is being cleared.
  assign s1i_rdy   = (cnt_q != 2'd2) && !rst;
  assign s1o_valid = (cnt_q != 2'd0);
  assign s1o_data  = head_q;

  assign push  = s1i_valid && s1i_rdy;
  assign pop   = s1o_valid && s1o_rdy;
  assign delta = s1i_data - prev_q;

  // Next-state for predecessor, buffer entries and occupancy.
  always_comb begin
    prev_d = prev_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    if (push) begin
      prev_d = s1i_data;
    end

    case ({push, pop})
      2'b10: begin
        // Push only: new word lands in the first free slot.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          head_d = delta;
        end else begin
          tail_d = delta;
        end
      end
      2'b01: begin
        // Pop only: surviving entry (if any) moves to the head.
        cnt_d  = cnt_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        // Push and pop: occupancy unchanged, new word goes behind the
        // surviving entry (or becomes head when the buffer held one word).
        if (cnt_q == 2'd1) begin
          head_d = delta;
        end else begin
          head_d = tail_q;
          tail_d = delta;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous reset; reset discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      prev_q <= prev_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef STREAM_DELTA_WORDCOUNT_EN
  logic [31:0] wcnt_q, wcnt_d;

  // Output-transfer counter, wraps naturally at 2^32.
  always_comb begin
    wcnt_d = wcnt_q + {31'd0, pop};
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= 32'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign word_count = wcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_delta_decoder.sv
// Testbench for stream_delta_decoder: directed vector table, a hand-written
// reset-mid-stream sequence and a randomized round trip through a
// behavioural running-sum encoder.
`default_nettype none

module tb_stream_delta_decoder;

  localparam int N = 1000;

  logic        clk;
  logic        rst;
  logic        s1i_valid;
  logic        s1i_rdy;
  logic [31:0] s1i_data;
  logic        s1o_valid;
  logic        s1o_rdy;
  logic [31:0] s1o_data;
`ifdef STREAM_DELTA_WORDCOUNT_EN
  logic [31:0] word_count;
`endif

  stream_delta_decoder #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .s1i_valid (s1i_valid),
    .s1i_rdy   (s1i_rdy),
    .s1i_data  (s1i_data),
    .s1o_valid (s1o_valid),
    .s1o_rdy   (s1o_rdy),
    .s1o_data  (s1o_data)
`ifdef STREAM_DELTA_WORDCOUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed per-cycle vectors: inputs driven just after the rising edge,
  // outputs compared at the falling edge of the same cycle.
  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] dat;
    logic        ordy;
    logic        e_ovld;
    logic [31:0] e_odat;
    logic        e_irdy;
  } vec_t;

  vec_t vt[18];

  // Behavioural model for the random phase: queue of expected outputs.
  bit          mon_en = 1'b0;
  logic [31:0] mq[$];
  logic [31:0] mprev = 32'd0;
  logic [31:0] recv[$];

  // Monitor: compares against the model, then advances it to the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("in_rdy_during_rst", {31'd0, s1i_rdy}, 32'd0);
        mq.delete();
        mprev = 32'd0;
      end else begin
        chk("in_rdy", {31'd0, s1i_rdy}, {31'd0, (mq.size() < 2)});
        chk("out_valid", {31'd0, s1o_valid}, {31'd0, (mq.size() != 0)});
        if (mq.size() != 0) chk("out_data", s1o_data, mq[0]);
        if (s1o_valid && s1o_rdy && mq.size() != 0) begin
          recv.push_back(s1o_data);
          void'(mq.pop_front());
        end
        if (s1i_valid && s1i_rdy) begin
          mq.push_back(s1i_data - mprev);
          mprev = s1i_data;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] orig[N];
  logic [31:0] cum[N];

  initial begin
    logic [31:0] acc;
    int          idx;
    int          cyc;
    bit          fire;

    vt[0]  = '{0, 1, 32'd5,          1, 0, 32'd0,          1};
    vt[1]  = '{0, 1, 32'd12,         1, 1, 32'd5,          1};
    vt[2]  = '{0, 1, 32'd12,         1, 1, 32'd7,          1};
    vt[3]  = '{0, 1, 32'd100,        1, 1, 32'd0,          1};
    vt[4]  = '{0, 0, 32'hDEADBEEF,   1, 1, 32'd88,         1};
    vt[5]  = '{1, 0, 32'd0,          1, 0, 32'd0,          0};
    vt[6]  = '{0, 1, 32'hFFFFFFF0,   1, 0, 32'd0,          1};
    vt[7]  = '{0, 1, 32'h00000010,   1, 1, 32'hFFFFFFF0,   1};
    vt[8]  = '{0, 0, 32'h12345678,   1, 1, 32'h00000020,   1};
    vt[9]  = '{1, 0, 32'd0,          0, 0, 32'd0,          0};
    vt[10] = '{0, 1, 32'd1,          0, 0, 32'd0,          1};
    vt[11] = '{0, 1, 32'd3,          0, 1, 32'd1,          1};
    vt[12] = '{0, 1, 32'd6,          0, 1, 32'd1,          0};
    vt[13] = '{0, 1, 32'd6,          0, 1, 32'd1,          0};
    vt[14] = '{0, 1, 32'd6,          1, 1, 32'd1,          0};
    vt[15] = '{0, 1, 32'd6,          1, 1, 32'd2,          1};
    vt[16] = '{0, 0, 32'd0,          1, 1, 32'd3,          1};
    vt[17] = '{0, 0, 32'd0,          1, 0, 32'd0,          1};

    // Reset state.
    rst = 1'b1; s1i_valid = 1'b0; s1i_data = 32'd0; s1o_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_rdy",    {31'd0, s1i_rdy},   32'd0);
    chk("reset_out_valid", {31'd0, s1o_valid}, 32'd0);
    chk("reset_out_data",  s1o_data,           32'd0);
`ifdef STREAM_DELTA_WORDCOUNT_EN
    chk("reset_word_count", word_count, 32'd0);
`endif

    // Directed table: basic decode, wrap-around, backpressure.
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      rst = vt[i].rst; s1i_valid = vt[i].vld; s1i_data = vt[i].dat; s1o_rdy = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_rdy", i),    {31'd0, s1i_rdy},   {31'd0, vt[i].e_irdy});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, s1o_valid}, {31'd0, vt[i].e_ovld});
      if (vt[i].e_ovld) chk($sformatf("vec%0d_out_data", i), s1o_data, vt[i].e_odat);
    end

    // Reset mid-stream (prev is 6 from the table): 10, 20 in; rst with the
    // word 10 buffered; then 7 must come out unchanged.
    @(posedge clk); #1; s1i_valid = 1'b1; s1i_data = 32'd10; s1o_rdy = 1'b1;
    @(posedge clk); #1; s1i_data = 32'd20;
    @(negedge clk);
    chk("rstmid_first_out", s1o_data, 32'd4);
    @(posedge clk); #1; s1i_valid = 1'b0; s1o_rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstmid_buffered_valid", {31'd0, s1o_valid}, 32'd1);
    chk("rstmid_buffered_data",  s1o_data, 32'd10);
    chk("rstmid_in_rdy_low",     {31'd0, s1i_rdy}, 32'd0);
    @(posedge clk); #1; rst = 1'b0; s1i_valid = 1'b1; s1i_data = 32'd7; s1o_rdy = 1'b1;
    @(negedge clk);
    chk("rstmid_valid_cleared", {31'd0, s1o_valid}, 32'd0);
    chk("rstmid_in_rdy_back",   {31'd0, s1i_rdy},   32'd1);
    @(posedge clk); #1; s1i_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_next_valid", {31'd0, s1o_valid}, 32'd1);
    chk("rstmid_next_data",  s1o_data, 32'd7);
    @(posedge clk); #1; s1o_rdy = 1'b0;
    @(negedge clk);
    chk("rstmid_drained", {31'd0, s1o_valid}, 32'd0);

    // Random round trip: original words -> running sum -> decoder.
    acc = 32'd0;
    for (int i = 0; i < N; i++) begin
      orig[i] = $urandom;
      acc     = acc + orig[i];
      cum[i]  = acc;
    end

    @(posedge clk); #1; rst = 1'b1; s1i_valid = 1'b0; s1o_rdy = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    idx = 0; cyc = 0;
    while ((idx < N || recv.size() < N) && cyc < 20000) begin
      @(negedge clk);
      fire = s1i_valid && s1i_rdy;
      @(posedge clk); #1;
      cyc++;
      if (fire) idx++;
      if (idx >= N) s1i_valid = 1'b0;
      else if (!s1i_valid || fire) s1i_valid = ($urandom_range(0, 3) != 0);
      s1i_data = s1i_valid ? cum[idx] : $urandom;
      s1o_rdy  = ($urandom_range(0, 2) != 0);
    end
    chk("roundtrip_in_time", {31'd0, (cyc < 20000)}, 32'd1);
    s1i_valid = 1'b0; s1o_rdy = 1'b0;
    repeat (2) @(negedge clk);

    chk("roundtrip_count", recv.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < recv.size()) chk($sformatf("roundtrip_word%0d", i), recv[i], orig[i]);
    end
`ifdef STREAM_DELTA_WORDCOUNT_EN
    chk("word_count_after_roundtrip", word_count, N);
`endif

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
